// File: rtl/or3_response_checker.sv
// or3_response_checker: response-side checker for a 3-input OR gate.
// Compares y against a|b|c on each valid sample during a run, tracks input
// coverage, counts mismatches (saturating), captures the first failing vector
// and reports a pass/fail verdict in DONE.

module or3_response_checker #(
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned TIMEOUT = 64   // legal range 8..65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       cov_map,
    output logic [3:0]       first_fail,
    output logic             first_fail_vld
);

    typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

    localparam logic [ERR_W-1:0] ErrMax      = '1;
    localparam logic [15:0]      TimeoutLast = 16'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       cov_q, cov_d;
    logic [3:0]       ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic             to_q, to_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [2:0]       idx;
    logic             mismatch;

    assign idx      = {a, b, c};
    assign mismatch = (y != (a | b | c));

    // Next-state and statistics update.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cov_d   = cov_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        to_d    = to_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StCheck;
                    err_d   = '0;
                    cov_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    to_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StCheck: begin
                cnt_d = cnt_q + 16'd1;
                if (valid) begin
                    cov_d[idx] = 1'b1;
                    if (mismatch) begin
                        if (err_q != ErrMax) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!ffv_q) begin
                            ff_d  = {a, b, c, y};
                            ffv_d = 1'b1;
                        end
                    end
                end
                // Coverage completion takes priority over a coincident timeout.
                if (cov_d == 8'hFF) begin
                    state_d = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StDone;
                    to_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            err_q   <= '0;
            cov_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy           = (state_q == StCheck);
        done           = (state_q == StDone);
        pass           = (state_q == StDone) && (err_q == '0) && (cov_q == 8'hFF) && !to_q;
        timeout        = to_q;
        err_count      = err_q;
        cov_map        = cov_q;
        first_fail     = ff_q;
        first_fail_vld = ffv_q;
    end

endmodule

// File: tb/tb_or3_response_checker.sv
// Directed self-checking bench for or3_response_checker. Three instances share
// the stimulus: default parameters, TIMEOUT=16, and ERR_W=2.

module tb_or3_response_checker;

    logic clk = 1'b0;
    logic rst, start, valid, a, b, c, y;

    logic       busy, done, pass, timeout, ffv;
    logic [7:0] err_count, cov_map;
    logic [3:0] ff;

    logic       busy_t, done_t, pass_t, timeout_t, ffv_t;
    logic [7:0] err_t, cov_t;
    logic [3:0] ff_t;

    logic       busy_s, done_s, pass_s, timeout_s, ffv_s;
    logic [1:0] err_s;
    logic [7:0] cov_s;
    logic [3:0] ff_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    or3_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .c(c), .y(y),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .cov_map(cov_map), .first_fail(ff), .first_fail_vld(ffv)
    );

    or3_response_checker #(.ERR_W(8), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .c(c), .y(y),
        .busy(busy_t), .done(done_t), .pass(pass_t), .timeout(timeout_t), .err_count(err_t),
        .cov_map(cov_t), .first_fail(ff_t), .first_fail_vld(ffv_t)
    );

    or3_response_checker #(.ERR_W(2), .TIMEOUT(64)) dut_s (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .c(c), .y(y),
        .busy(busy_s), .done(done_s), .pass(pass_s), .timeout(timeout_s), .err_count(err_s),
        .cov_map(cov_s), .first_fail(ff_s), .first_fail_vld(ffv_s)
    );

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic sample(input logic [2:0] v, input logic yv);
        valid = 1'b1;
        {a, b, c} = v;
        y = yv;
        cyc();
        valid = 1'b0;
        {a, b, c, y} = 4'bxxxx;
    endtask

    task automatic good_sweep();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            sample(v, |v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; valid = 1'b1; {a, b, c, y} = 4'b1000;
        cyc();
        start = 1'b0; valid = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got busy=%b done=%b pass=%b to=%b want 0000",
                              busy, done, pass, timeout);
        end
        n_cmp++; if (err_count !== 8'h00 || cov_map !== 8'h00 || ff !== 4'h0 || ffv !== 1'b0) begin
            n_bad++; $display("FAIL reset_stats: got err=%h cov=%h ff=%h ffv=%b want 0",
                              err_count, cov_map, ff, ffv);
        end
        n_cmp++; if (busy_t !== 1'b0 || busy_s !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy_others: got %b%b want 00", busy_t, busy_s);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_valid();
        sample(3'b101, 1'b0);
        sample(3'b111, 1'b1);
        n_cmp++; if (cov_map !== 8'h00 || err_count !== 8'h00 || ffv !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_valid: got cov=%h err=%h ffv=%b busy=%b want 00 00 0 0",
                              cov_map, err_count, ffv, busy);
        end
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || cov_map !== 8'h00) begin
            n_bad++; $display("FAIL idle_then_start: got busy=%b cov=%h want 1 00", busy, cov_map);
        end
        good_sweep();
        n_cmp++; if (done !== 1'b1 || pass !== 1'b1) begin
            n_bad++; $display("FAIL idle_run_end: got done=%b pass=%b want 1 1", done, pass);
        end
    endtask

    task automatic test_good();
        pulse_start();
        n_cmp++; if (cov_map !== 8'h00 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL good_restart: got cov=%h busy=%b done=%b want 00 1 0",
                              cov_map, busy, done);
        end
        for (int i = 0; i < 7; i++) sample(3'(i), (i != 0));
        n_cmp++; if (done !== 1'b0 || cov_map !== 8'h7F) begin
            n_bad++; $display("FAIL good_before_last: got done=%b cov=%h want 0 7f", done, cov_map);
        end
        sample(3'd7, 1'b1);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
            n_bad++; $display("FAIL good_done: got done=%b busy=%b pass=%b want 1 0 1",
                              done, busy, pass);
        end
        n_cmp++; if (err_count !== 8'h00 || cov_map !== 8'hFF || timeout !== 1'b0 || ffv !== 1'b0)
        begin
            n_bad++; $display("FAIL good_stats: got err=%h cov=%h to=%b ffv=%b want 00 ff 0 0",
                              err_count, cov_map, timeout, ffv);
        end
    endtask

    task automatic test_stuck0();
        pulse_start();
        for (int i = 0; i < 8; i++) sample(3'(i), 1'b0);
        n_cmp++; if (err_count !== 8'd7 || pass !== 1'b0 || done !== 1'b1) begin
            n_bad++; $display("FAIL stuck0_err: got err=%0d pass=%b done=%b want 7 0 1",
                              err_count, pass, done);
        end
        n_cmp++; if (ff !== 4'b0010 || ffv !== 1'b1) begin
            n_bad++; $display("FAIL stuck0_first: got ff=%b ffv=%b want 0010 1", ff, ffv);
        end
    endtask

    task automatic test_start_in_done();
        pulse_start();
        n_cmp++; if (err_count !== 8'h00 || ffv !== 1'b0 || ff !== 4'h0 || busy !== 1'b1 ||
                     done !== 1'b0) begin
            n_bad++; $display("FAIL done_restart: got err=%h ffv=%b ff=%h busy=%b done=%b want 0 0 0 1 0",
                              err_count, ffv, ff, busy, done);
        end
        good_sweep();
        n_cmp++; if (pass !== 1'b1) begin
            n_bad++; $display("FAIL done_restart_pass: got %b want 1", pass);
        end
    endtask

    task automatic test_start_in_check();
        pulse_start();
        sample(3'd0, 1'b0);
        sample(3'd1, 1'b1);
        sample(3'd2, 1'b0);
        sample(3'd3, 1'b1);
        start = 1'b1;
        sample(3'd4, 1'b1);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || cov_map !== 8'h1F || err_count !== 8'd1) begin
            n_bad++; $display("FAIL check_start_ignored: got busy=%b cov=%h err=%0d want 1 1f 1",
                              busy, cov_map, err_count);
        end
        sample(3'd5, 1'b1);
        sample(3'd6, 1'b1);
        sample(3'd7, 1'b1);
        n_cmp++; if (done !== 1'b1 || err_count !== 8'd1 || pass !== 1'b0 || ff !== 4'b0100) begin
            n_bad++; $display("FAIL check_start_end: got done=%b err=%0d pass=%b ff=%b want 1 1 0 0100",
                              done, err_count, pass, ff);
        end
    endtask

    task automatic test_timeout();
        pulse_start();
        for (int k = 1; k <= 16; k++) begin
            sample(3'((k - 1) % 6), ((k - 1) % 6) != 0);
            if (k == 15) begin
                n_cmp++; if (done_t !== 1'b0 || busy_t !== 1'b1) begin
                    n_bad++; $display("FAIL timeout_early: got done=%b busy=%b want 0 1",
                                      done_t, busy_t);
                end
            end
        end
        n_cmp++; if (done_t !== 1'b1 || timeout_t !== 1'b1 || pass_t !== 1'b0) begin
            n_bad++; $display("FAIL timeout_done: got done=%b to=%b pass=%b want 1 1 0",
                              done_t, timeout_t, pass_t);
        end
        n_cmp++; if (cov_t !== 8'h3F || err_t !== 8'h00) begin
            n_bad++; $display("FAIL timeout_cov: got cov=%h err=%h want 3f 00", cov_t, err_t);
        end
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL timeout_default_busy: got busy=%b done=%b want 1 0", busy, done);
        end
        sample(3'd6, 1'b1);
        sample(3'd7, 1'b1);
        n_cmp++; if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0 || cov_t !== 8'h3F) begin
            n_bad++; $display("FAIL timeout_tail: got done=%b pass=%b to=%b cov_t=%h want 1 1 0 3f",
                              done, pass, timeout, cov_t);
        end
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int i = 0; i < 5; i++) sample(3'(i), (i == 0));
        for (int i = 5; i < 8; i++) sample(3'(i), 1'b1);
        n_cmp++; if (err_s !== 2'd3 || pass_s !== 1'b0 || done_s !== 1'b1) begin
            n_bad++; $display("FAIL sat_err: got err=%0d pass=%b done=%b want 3 0 1",
                              err_s, pass_s, done_s);
        end
        n_cmp++; if (err_count !== 8'd5 || ff !== 4'b0001) begin
            n_bad++; $display("FAIL sat_wide_err: got err=%0d ff=%b want 5 0001", err_count, ff);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        sample(3'd0, 1'b0);
        sample(3'd1, 1'b0);
        sample(3'd2, 1'b1);
        sample(3'd3, 1'b1);
        n_cmp++; if (err_count !== 8'd1 || ffv !== 1'b1) begin
            n_bad++; $display("FAIL midrun_pre: got err=%0d ffv=%b want 1 1", err_count, ffv);
        end
        rst = 1'b1; start = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 8'h00 ||
                     cov_map !== 8'h00 || ff !== 4'h0 || ffv !== 1'b0 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL midrun_reset: got busy=%b done=%b pass=%b err=%h cov=%h ff=%h ffv=%b to=%b want all 0",
                              busy, done, pass, err_count, cov_map, ff, ffv, timeout);
        end
        pulse_start();
        good_sweep();
        n_cmp++; if (pass !== 1'b1 || cov_map !== 8'hFF) begin
            n_bad++; $display("FAIL midrun_fresh: got pass=%b cov=%h want 1 ff", pass, cov_map);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; {a, b, c, y} = 4'b0000;
        cyc();
        test_reset();
        test_idle_valid();
        test_good();
        test_stuck0();
        test_start_in_done();
        test_start_in_check();
        test_timeout();
        test_saturation();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
